// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a negedge-clocked 1Kx32 BRAM.
// Port I is instruction fetch (read only); port D is load/store, with
// read-modify-write for partial-word stores.
//
// Handshake: a requester raises req with stable addr/we/be/wdata and holds
// them until its ack pulses for exactly one cycle; in the cycle after ack it
// either drops req or presents the next request. A port whose ack is high
// this cycle is not eligible, so a retiring request is never granted twice.
module mem_arbiter #(
  parameter int WORDS      = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    i_req_i,
  input  logic [WORDS+1:0]        i_addr_i,
  output logic                    i_ack_o,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  input  logic [WORDS+1:0]        d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  output logic                    d_ack_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    busy_o,
  output logic [WORDS-1:0]        mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_data_o,
  output logic                    mem_rd_no,
  output logic                    mem_wr_no,
  input  logic [DATA_WIDTH-1:0]   mem_data_i
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4
  } state_t;

  state_t                state, state_nx;
  logic                  last_grant_d, last_grant_d_nx;  // 1: D was granted last
  logic                  gnt_d, gnt_d_nx;                // owner of the current access
  logic                  zero_pend, zero_pend_nx;        // be==0 store awaiting its ack
  logic [BE_W-1:0]       be_q, be_nx;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_nx;
  logic [WORDS-1:0]      mem_addr_nx;
  logic [DATA_WIDTH-1:0] mem_data_nx;
  logic                  mem_rd_n_nx, mem_wr_n_nx;
  logic                  i_ack_nx, d_ack_nx;
  logic [DATA_WIDTH-1:0] i_rdata_nx, d_rdata_nx;
  logic [DATA_WIDTH-1:0] merged;
  logic                  i_elig, d_elig, pick_d;

  // Byte addressing bits [1:0] are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr_i[1:0], d_addr_i[1:0]};

  assign busy_o = (state != IDLE);

  // Byte-lane merge of the store data over the word just read back.
  always_comb begin
    merged = mem_data_i;
    for (int b = 0; b < BE_W; b++) begin
      if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  // Eligibility and round-robin choice; D wins only if I is not eligible
  // or I was the last port granted.
  always_comb begin
    i_elig = i_req_i & ~i_ack_o;
    d_elig = d_req_i & ~d_ack_o & ~zero_pend;
    pick_d = d_elig & (~i_elig | ~last_grant_d);
  end

  // Next-state and registered-output logic; strobes default inactive.
  always_comb begin
    state_nx        = state;
    last_grant_d_nx = last_grant_d;
    gnt_d_nx        = gnt_d;
    zero_pend_nx    = 1'b0;
    be_nx           = be_q;
    wdata_nx        = wdata_q;
    mem_addr_nx     = mem_addr_o;
    mem_data_nx     = mem_data_o;
    mem_rd_n_nx     = 1'b1;
    mem_wr_n_nx     = 1'b1;
    i_ack_nx        = 1'b0;
    d_ack_nx        = zero_pend;
    i_rdata_nx      = i_rdata_o;
    d_rdata_nx      = d_rdata_o;

    unique case (state)
      IDLE: begin
        if (i_elig | d_elig) begin
          last_grant_d_nx = pick_d;
          gnt_d_nx        = pick_d;
          if (!pick_d) begin
            mem_addr_nx = i_addr_i[WORDS+1:2];
            mem_rd_n_nx = 1'b0;
            state_nx    = READ;
          end else if (!d_we_i) begin
            mem_addr_nx = d_addr_i[WORDS+1:2];
            mem_rd_n_nx = 1'b0;
            state_nx    = READ;
          end else if (&d_be_i) begin
            mem_addr_nx = d_addr_i[WORDS+1:2];
            mem_data_nx = d_wdata_i;
            mem_wr_n_nx = 1'b0;
            state_nx    = WRITE;
          end else if (|d_be_i) begin
            mem_addr_nx = d_addr_i[WORDS+1:2];
            be_nx       = d_be_i;
            wdata_nx    = d_wdata_i;
            mem_rd_n_nx = 1'b0;
            state_nx    = RMW_RD;
          end else begin
            zero_pend_nx = 1'b1;
          end
        end
      end
      READ: begin
        if (gnt_d) begin
          d_rdata_nx = mem_data_i;
          d_ack_nx   = 1'b1;
        end else begin
          i_rdata_nx = mem_data_i;
          i_ack_nx   = 1'b1;
        end
        state_nx = IDLE;
      end
      WRITE: begin
        d_ack_nx = 1'b1;
        state_nx = IDLE;
      end
      RMW_RD: begin
        mem_data_nx = merged;
        mem_wr_n_nx = 1'b0;
        state_nx    = RMW_WR;
      end
      RMW_WR: begin
        d_ack_nx = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers; reset forces both strobes inactive at once.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      gnt_d        <= 1'b0;
      zero_pend    <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      mem_rd_no    <= 1'b1;
      mem_wr_no    <= 1'b1;
      i_ack_o      <= 1'b0;
      d_ack_o      <= 1'b0;
      i_rdata_o    <= '0;
      d_rdata_o    <= '0;
    end else begin
      state        <= state_nx;
      last_grant_d <= last_grant_d_nx;
      gnt_d        <= gnt_d_nx;
      zero_pend    <= zero_pend_nx;
      be_q         <= be_nx;
      wdata_q      <= wdata_nx;
      mem_addr_o   <= mem_addr_nx;
      mem_data_o   <= mem_data_nx;
      mem_rd_no    <= mem_rd_n_nx;
      mem_wr_no    <= mem_wr_n_nx;
      i_ack_o      <= i_ack_nx;
      d_ack_o      <= d_ack_nx;
      i_rdata_o    <= i_rdata_nx;
      d_rdata_o    <= d_rdata_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a negedge-clocked 1Kx32 memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        i_req;
  logic [11:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [11:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        busy;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd_n;
  logic        mem_wr_n;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];

  int n_checks;
  int n_errors;

  mem_arbiter #(.WORDS(10), .DATA_WIDTH(32)) dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .i_req_i    (i_req),
    .i_addr_i   (i_addr),
    .i_ack_o    (i_ack),
    .i_rdata_o  (i_rdata),
    .d_req_i    (d_req),
    .d_we_i     (d_we),
    .d_be_i     (d_be),
    .d_addr_i   (d_addr),
    .d_wdata_i  (d_wdata),
    .d_ack_o    (d_ack),
    .d_rdata_o  (d_rdata),
    .busy_o     (busy),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_wdata),
    .mem_rd_no  (mem_rd_n),
    .mem_wr_no  (mem_wr_n),
    .mem_data_i (mem_rdata)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: samples strobes on the negedge
  always @(negedge clk) begin
    if (!mem_rd_n) mem_rdata <= mem[mem_addr];
    if (!mem_wr_n) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One port-D transaction from an idle arbiter; lat counts cycles after grant.
  task automatic run_d(input string tag, input logic we, input logic [3:0] be,
                       input logic [11:0] addr, input logic [31:0] wdata,
                       input int exp_lat, input int exp_rd, input int exp_wr,
                       input logic [31:0] exp_val);
    int rd_cnt;
    int wr_cnt;
    int lat;
    logic [31:0] wseen;
    rd_cnt = 0; wr_cnt = 0; lat = -1; wseen = '0;
    d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (!mem_rd_n) rd_cnt++;
      if (!mem_wr_n) begin
        wr_cnt++;
        wseen = mem_wdata;
      end
      check({tag, "_strobe_excl"}, 32'(!mem_rd_n && !mem_wr_n), 32'd0);
      if (d_ack) lat = c - 1;
    end
    d_req = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rd_cycles"}, 32'(rd_cnt), 32'(exp_rd));
    check({tag, "_wr_cycles"}, 32'(wr_cnt), 32'(exp_wr));
    if (!we) check({tag, "_rdata"}, d_rdata, exp_val);
    else if (exp_wr > 0) check({tag, "_wdata"}, wseen, exp_val);
    @(posedge clk); #1;
    check({tag, "_ack_width"}, 32'(d_ack), 32'd0);
  endtask

  initial begin
    logic [1:0] order [4];
    int nack;
    n_checks = 0; n_errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[2]  = 32'h0000_0006;
    mem[3]  = 32'h0000_0033;
    mem[5]  = 32'h1111_000B;
    mem[7]  = 32'h7777_7777;
    mem[20] = 32'h0000_5050;
    mem_rdata = '0;
    reset_n = 1'b0;
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_n", 32'(mem_rd_n), 32'd1);
    check("rst_wr_n", 32'(mem_wr_n), 32'd1);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_acks", 32'({i_ack, d_ack}), 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: instruction fetch of word 2
    i_req = 1'b1; i_addr = 12'h008;
    @(posedge clk); #1;
    check("t1_rd_low", 32'(mem_rd_n), 32'd0);
    check("t1_addr", 32'(mem_addr), 32'd2);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_no_early_ack", 32'(i_ack), 32'd0);
    @(posedge clk); #1;
    check("t1_ack", 32'(i_ack), 32'd1);
    check("t1_rdata", i_rdata, 32'h0000_0006);
    check("t1_rd_high", 32'(mem_rd_n), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);
    i_req = 1'b0;
    @(posedge clk); #1;
    check("t1_ack_width", 32'(i_ack), 32'd0);
    check("t1_rdata_hold", i_rdata, 32'h0000_0006);

    // 2: full-word store then read-back
    run_d("t2_st", 1'b1, 4'b1111, 12'h010, 32'hDEAD_BEEF, 1, 0, 1, 32'hDEAD_BEEF);
    check("t2_mem4", mem[4], 32'hDEAD_BEEF);
    run_d("t2_ld", 1'b0, 4'b0000, 12'h010, 32'h0, 1, 1, 0, 32'hDEAD_BEEF);

    // 3: byte-lane store through read-modify-write
    run_d("t3_rmw", 1'b1, 4'b0010, 12'h014, 32'h0000_AA00, 2, 1, 1, 32'h1111_AA0B);
    check("t3_mem5", mem[5], 32'h1111_AA0B);
    run_d("t3_ld", 1'b0, 4'b0000, 12'h014, 32'h0, 1, 1, 0, 32'h1111_AA0B);

    // 4: both ports requesting continuously; last grant was D so I leads
    nack = 0;
    for (int k = 0; k < 4; k++) order[k] = 2'd0;
    i_req = 1'b1; i_addr = 12'h00C;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'b0000; d_addr = 12'h050;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      check("t4_strobe_excl", 32'(!mem_rd_n && !mem_wr_n), 32'd0);
      check("t4_dual_ack", 32'(i_ack && d_ack), 32'd0);
      if (i_ack && nack < 4) begin order[nack] = 2'd1; nack++; end
      if (d_ack && nack < 4) begin order[nack] = 2'd2; nack++; end
    end
    i_req = 1'b0; d_req = 1'b0;
    check("t4_ack_count", 32'(nack), 32'd4);
    check("t4_order0", 32'(order[0]), 32'd1);
    check("t4_order1", 32'(order[1]), 32'd2);
    check("t4_order2", 32'(order[2]), 32'd1);
    check("t4_order3", 32'(order[3]), 32'd2);
    check("t4_i_rdata", i_rdata, 32'h0000_0033);
    check("t4_d_rdata", d_rdata, 32'h0000_5050);
    repeat (3) @(posedge clk);
    #1;
    check("t4_settled", 32'(busy), 32'd0);

    // 5: store with no byte enables touches no memory
    run_d("t5_be0", 1'b1, 4'b0000, 12'h018, 32'hFFFF_FFFF, 1, 0, 0, 32'h0);
    check("t5_mem6", mem[6], 32'h0);

    // 6: reset during RMW read phase aborts the store
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0001; d_addr = 12'h01C; d_wdata = 32'h0000_00FF;
    @(posedge clk); #1;
    check("t6_rmw_rd", 32'(mem_rd_n), 32'd0);
    reset_n = 1'b0;
    #1;
    check("t6_rd_n", 32'(mem_rd_n), 32'd1);
    check("t6_wr_n", 32'(mem_wr_n), 32'd1);
    check("t6_acks", 32'({i_ack, d_ack}), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_mem7", mem[7], 32'h7777_7777);
    check("t6_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 1Kx32 negedge-clocked BRAM `Memory`.
- Port I is the read-only instruction fetch port; port D is the load/store port.
- Grants one requester at a time using round-robin, and drives Memory's active-low rd/wr strobes, word address and write data.
- Performs read-modify-write for partial-word (byte/halfword) stores.

Parameters:
WORDS, 10, log2 of memory depth in 32-bit words; byte address width is WORDS+2
DATA_WIDTH, 32, word width; byte-enable width is DATA_WIDTH/8

Ports:
clk_i  in  1  clock; all arbiter state updates on posedge
reset_ni  in  1  asynchronous active-low reset
i_req_i  in  1  fetch request; held high until i_ack_o
i_addr_i  in  WORDS+2  fetch byte address; bits [1:0] ignored
i_ack_o  out  1  one-cycle completion pulse for port I
i_rdata_o  out  DATA_WIDTH  fetched word; holds until the next port-I read completes
d_req_i  in  1  data request; held high until d_ack_o
d_we_i  in  1  1=store, 0=load
d_be_i  in  DATA_WIDTH/8  store byte enables, lane-positioned
d_addr_i  in  WORDS+2  data byte address; bits [1:0] ignored
d_wdata_i  in  DATA_WIDTH  store data, lane-positioned
d_ack_o  out  1  one-cycle completion pulse for port D
d_rdata_o  out  DATA_WIDTH  loaded word; holds until the next port-D load completes
busy_o  out  1  high whenever state is not IDLE
mem_addr_o  out  WORDS  word address to Memory
mem_data_o  out  DATA_WIDTH  write data to Memory
mem_rd_no  out  1  Memory read enable, active low
mem_wr_no  out  1  Memory write enable, active low
mem_data_i  in  DATA_WIDTH  Memory read data, valid after the negedge following mem_rd_no low

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; mem_rd_no=1, mem_wr_no=1; mem_addr_o=0, mem_data_o=0.
  - i_ack_o=d_ack_o=0; i_rdata_o=d_rdata_o=0; busy_o=0.
  - last_grant=D, so port I wins the first tie.
  - Reset asserted before a pending negedge suppresses that memory write.
- All mem_* outputs are registered. Memory samples them on the negedge inside the same cycle.
- States: IDLE, READ, WRITE, RMW_RD, RMW_WR.
- IDLE, on each posedge:
  - Eligible = req high AND that port's ack_o not high this cycle (prevents re-granting a request that is just retiring).
  - Both eligible: grant the port != last_grant. Then set last_grant=granted port.
  - Port I or D load: mem_addr_o=addr[WORDS+1:2], mem_rd_no=0 -> READ.
  - D store with be all ones: mem_data_o=d_wdata_i, mem_wr_no=0 -> WRITE.
  - D store with partial be: mem_rd_no=0 -> RMW_RD.
  - D store with be==0: no memory access; d_ack_o=1 at the next posedge; stay IDLE.
- READ: capture mem_data_i into the granted port's rdata_o, pulse its ack_o, mem_rd_no=1 -> IDLE. Load latency: ack at the 1st posedge after grant.
- WRITE: mem_wr_no=1, pulse d_ack_o -> IDLE. Latency 1.
- RMW_RD: merged = per byte lane, be ? d_wdata_i : mem_data_i. Then mem_data_o=merged, mem_rd_no=1, mem_wr_no=0 -> RMW_WR.
- RMW_WR: mem_wr_no=1, pulse d_ack_o -> IDLE. Latency 2.
- mem_rd_no and mem_wr_no are never low in the same cycle.
- Request inputs are sampled only in IDLE. Address, data, be and we must stay stable until ack; the arbiter latches them at grant.
- ack_o is exactly one cycle wide. The requester drops req, or presents a new request, in the cycle after ack.
- The other port may be granted in the cycle its peer's ack is high (back-to-back).

Test Plan:
1. Reset, then i_req_i=1 with i_addr_i=0x008 and mem[2]=0x00000006 -> mem_rd_no low for 1 cycle; i_ack_o pulses at edge 1; i_rdata_o=0x00000006.
2. d store be=4'b1111, addr 0x010, data 0xDEADBEEF -> one mem_wr_no-low cycle at word 4; d_ack_o at edge 1. A subsequent load returns 0xDEADBEEF.
3. mem[5]=0x1111000B; d store be=4'b0010, data 0x0000AA00, addr 0x014 -> read cycle then write cycle with mem_data_o=0x1111AA0B; d_ack_o at edge 2.
4. i_req_i and d_req_i both high continuously (D load from 0x050) -> grants alternate I, D, I, D starting with I. No port is granted twice while the other waits; no cycle has both strobes low.
5. d store be=0 -> d_ack_o after 1 cycle; mem_wr_no and mem_rd_no stay high throughout.
6. Assert reset_ni low mid-RMW_RD -> immediately mem_rd_no=mem_wr_no=1, acks 0, busy_o=0; target word is unchanged after release.
